// File: rtl/handle_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one handle_handler,
// one transaction at a time (IDLE -> ISSUE -> RESP), with an optional sticky lock.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module handle_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned LOCK_TIMEOUT = 16
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic [NUM_REQ-1:0]          i_req_valid,
   input  logic [NUM_REQ-1:0]          i_req_lock,
   input  logic [3*NUM_REQ-1:0]        i_req_op,
   input  logic [NUM_REQ*`ADDR_WIDTH-1:0] i_req_address,
   input  logic [NUM_REQ*`ADDR_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]          o_req_ready,
   output logic [NUM_REQ-1:0]          o_rsp_valid,
   output logic [2:0]                  o_rsp_op,
   output logic [`ADDR_WIDTH-1:0]      o_rsp_address,
   output logic [`ADDR_WIDTH-1:0]      o_rsp_data,
   output logic [2:0]                  o_op,
   output logic [`ADDR_WIDTH-1:0]      o_address,
   output logic [`ADDR_WIDTH-1:0]      o_data,
   input  logic [2:0]                  i_op,
   input  logic [`ADDR_WIDTH-1:0]      i_address,
   input  logic [`ADDR_WIDTH-1:0]      i_data
);
   localparam int unsigned AW = `ADDR_WIDTH;
   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [2:0]  OP_NOP   = 3'd0;
   localparam logic [2:0]  OP_READ  = 3'd1;
   localparam logic [2:0]  OP_WRITE = 3'd2;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t               state;
   logic [IW-1:0]        last_grant;
   logic [IW-1:0]        grant;
   logic                 lock_active;
   logic [IW-1:0]        lock_owner;
   logic [CW-1:0]        lock_cnt;

   logic [2:0]           slot_op   [NUM_REQ];
   logic [AW-1:0]        slot_addr [NUM_REQ];
   logic [AW-1:0]        slot_data [NUM_REQ];
   logic [NUM_REQ-1:0]   eligible;
   logic                 win_found;
   logic [IW-1:0]        win_idx;
   logic [IW-1:0]        cand;
   logic [2:0]           sel_op;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign slot_op[g]   = i_req_op[3*g +: 3];
      assign slot_addr[g] = i_req_address[AW*g +: AW];
      assign slot_data[g] = i_req_data[AW*g +: AW];
   end

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IW'(s);
   endfunction

   // Round-robin search upward from last_grant+1; a held lock narrows eligibility to its owner.
   always_comb begin
      eligible  = lock_active ? (NUM_REQ'(1) << lock_owner) : '1;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = next_idx(last_grant, i);
         if (!win_found && i_req_valid[cand] && eligible[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign sel_op      = slot_op[win_idx];
   assign o_req_ready = (state == IDLE && win_found && !i_reset) ? (NUM_REQ'(1) << win_idx) : '0;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state         <= IDLE;
         last_grant    <= IW'(NUM_REQ - 1);
         grant         <= '0;
         lock_active   <= 1'b0;
         lock_owner    <= '0;
         lock_cnt      <= '0;
         o_rsp_valid   <= '0;
         o_rsp_op      <= OP_NOP;
         o_rsp_address <= '0;
         o_rsp_data    <= '0;
         o_op          <= OP_NOP;
         o_address     <= '0;
         o_data        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  state       <= ISSUE;
                  grant       <= win_idx;
                  last_grant  <= win_idx;
                  lock_active <= i_req_lock[win_idx];
                  lock_owner  <= win_idx;
                  lock_cnt    <= '0;
                  o_op        <= (sel_op == OP_READ || sel_op == OP_WRITE) ? sel_op : OP_NOP;
                  o_address   <= slot_addr[win_idx];
                  o_data      <= slot_data[win_idx];
               end else if (lock_active) begin
                  // No winner while locked means the owner is idle: age the lock.
                  if (lock_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                     lock_active <= 1'b0;
                     lock_cnt    <= '0;
                  end else begin
                     lock_cnt <= lock_cnt + 1'b1;
                  end
               end
            end
            ISSUE: begin
               state         <= RESP;
               o_op          <= OP_NOP;
               o_address     <= '0;
               o_data        <= '0;
               o_rsp_op      <= i_op;
               o_rsp_address <= i_address;
               o_rsp_data    <= i_data;
               o_rsp_valid   <= NUM_REQ'(1) << grant;
            end
            RESP: begin
               state       <= IDLE;
               o_rsp_valid <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
